// File: rtl/ni_tx_if.sv
// Core/router-facing signal bundle for the NI transmitter: send requests,
// payload words, outgoing flits and returning credits.
interface ni_tx_if #(
  parameter int x_Des_Addr_Size = 5,
  parameter int y_Des_Addr_Size = 5,
  parameter int FLIT_W          = 32,
  parameter int LEN_W           = 4
);
  logic                       req_valid;
  logic                       req_ready;
  logic [x_Des_Addr_Size-1:0] x_Dest;
  logic [y_Des_Addr_Size-1:0] y_Dest;
  logic [LEN_W-1:0]           pkt_len;
  logic                       data_valid;
  logic                       data_ready;
  logic [FLIT_W-3:0]          data_in;
  logic                       flit_valid;
  logic [FLIT_W-1:0]          flit_out;
  logic                       credit_in;
  logic                       credit_err;

  modport slave (
    input  req_valid, x_Dest, y_Dest, pkt_len, data_valid, data_in, credit_in,
    output req_ready, data_ready, flit_valid, flit_out, credit_err
  );

  modport master (
    output req_valid, x_Dest, y_Dest, pkt_len, data_valid, data_in, credit_in,
    input  req_ready, data_ready, flit_valid, flit_out, credit_err
  );
endinterface

// File: rtl/ni_packetizer_tx.sv
// NI transmitter: packs send requests into HEAD/BODY/TAIL flits under credit flow control.
// Optional macro NI_TX_CREDIT_CHECK_EN enables the sticky credit-overflow flag.
module ni_packetizer_tx #(
  parameter int x_Des_Addr_Size = 5,
  parameter int y_Des_Addr_Size = 5,
  parameter int FLIT_W          = 32,
  parameter int LEN_W           = 4,
  parameter int BUFFER_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  ni_tx_if.slave   nif
);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam int PW = FLIT_W - 2;
  localparam int XY = x_Des_Addr_Size + y_Des_Addr_Size;

  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                     state, state_nxt;
  logic [x_Des_Addr_Size-1:0] x_q;
  logic [y_Des_Addr_Size-1:0] y_q;
  logic [LEN_W-1:0]           len_q, rem;
  logic [CW-1:0]              credits;
  logic                       has_cred;
  logic                       req_ready_c, data_ready_c, issue;
  logic [1:0]                 ftype;
  logic [PW-1:0]              fpay, head_pay;
  logic                       flit_valid_q;
  logic [FLIT_W-1:0]          flit_out_q;

  assign has_cred = (credits != '0);

  always_comb begin
    head_pay         = '0;
    head_pay[XY-1:0] = {y_q, x_q};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (nif.req_valid) state_nxt = HEAD;
      HEAD: if (has_cred) state_nxt = (len_q == '0) ? IDLE : BODY;
      BODY: if (issue && rem == LEN_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c  = 1'b0;
    data_ready_c = 1'b0;
    issue        = 1'b0;
    ftype        = T_HEAD;
    fpay         = head_pay;
    case (state)
      IDLE: req_ready_c = 1'b1;
      HEAD: begin
        issue = has_cred;
        ftype = (len_q == '0) ? T_HT : T_HEAD;
      end
      BODY: begin
        data_ready_c = has_cred;
        issue        = nif.data_valid && has_cred;
        ftype        = (rem == LEN_W'(1)) ? T_TAIL : T_BODY;
        fpay         = nif.data_in;
      end
      default: ;
    endcase
  end

  assign nif.req_ready  = req_ready_c;
  assign nif.data_ready = data_ready_c;
  assign nif.flit_valid = flit_valid_q;
  assign nif.flit_out   = flit_out_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      len_q <= '0;
      rem   <= '0;
    end else begin
      if (state == IDLE && nif.req_valid) begin
        x_q   <= nif.x_Dest;
        y_q   <= nif.y_Dest;
        len_q <= nif.pkt_len;
      end
      if (state == HEAD && issue)      rem <= len_q;
      else if (state == BODY && issue) rem <= rem - LEN_W'(1);
    end

  // Flit output is a registered copy of whatever was issued this cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flit_valid_q <= 1'b0;
      flit_out_q   <= '0;
    end else begin
      flit_valid_q <= issue;
      flit_out_q   <= issue ? {ftype, fpay} : '0;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) credits <= CW'(BUFFER_DEPTH);
    else case ({issue, nif.credit_in})
      2'b10:   credits <= credits - CW'(1);
      2'b01:   if (credits != CW'(BUFFER_DEPTH)) credits <= credits + CW'(1);
      default: ;
    endcase

`ifdef NI_TX_CREDIT_CHECK_EN
  logic credit_err_q;
  // A credit arriving with the buffer already fully credited means the router
  // returned more than it was sent; latch it until reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) credit_err_q <= 1'b0;
    else if (nif.credit_in && !issue && credits == CW'(BUFFER_DEPTH)) credit_err_q <= 1'b1;
  assign nif.credit_err = credit_err_q;
`else
  assign nif.credit_err = 1'b0;
`endif
endmodule

// File: tb/tb_ni_packetizer_tx.sv
// Bench for ni_packetizer_tx: directed scenarios plus random packets against a
// flit-queue model and a credit-returning router model.
module tb_ni_packetizer_tx;
  localparam int XW = 5, YW = 5, FW = 32, LW = 4, BD = 4;
`ifdef NI_TX_CREDIT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ni_tx_if #(.x_Des_Addr_Size(XW), .y_Des_Addr_Size(YW), .FLIT_W(FW), .LEN_W(LW)) nif ();

  ni_packetizer_tx #(.x_Des_Addr_Size(XW), .y_Des_Addr_Size(YW), .FLIT_W(FW),
                     .LEN_W(LW), .BUFFER_DEPTH(BD)) dut (.clk(clk), .rst(rst), .nif(nif));

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] expq[$];

  always @(negedge clk)
    if (nif.flit_valid === 1'b1) begin
      got.push_back(nif.flit_out);
      got_cyc.push_back(cyc);
    end

  // Router model: returns one credit per received flit after rtr_dly cycles.
  bit rtr_en = 1'b0;
  int rtr_dly = 2;
  int due[$];
  int seen = 0, given = 0, max_out = 0;
  initial begin
    nif.credit_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        due.delete();
        seen = 0;
        given = 0;
        nif.credit_in = 1'b0;
      end else begin
        if (nif.flit_valid === 1'b1) begin
          seen++;
          if (rtr_en) due.push_back(cyc + rtr_dly);
        end
        if (seen - given > max_out) max_out = seen - given;
        if (due.size() > 0 && due[0] <= cyc) begin
          void'(due.pop_front());
          nif.credit_in = 1'b1;
          given++;
        end else nif.credit_in = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [29:0] wq[$];
  int widx, acc_cyc, rr_viol;
  int vprob = 100;

  function automatic logic [31:0] mkf(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic start_pkt(input logic [4:0] x, input logic [4:0] y, input logic [3:0] len,
                           input bit fixed);
    int b = 0;
    logic [29:0] w;
    wq.delete();
    widx = 0;
    rr_viol = 0;
    if (len == 0) expq.push_back(mkf(2'b11, {20'b0, y, x}));
    else begin
      expq.push_back(mkf(2'b00, {20'b0, y, x}));
      for (int i = 0; i < int'(len); i++) begin
        w = fixed ? 30'(32'hA + i) : 30'($urandom);
        wq.push_back(w);
        expq.push_back(mkf((i == int'(len) - 1) ? 2'b10 : 2'b01, w));
      end
    end
    @(negedge clk);
    while (nif.req_ready !== 1'b1 && b < 50) begin @(negedge clk); b++; end
    if (b >= 50) chk("req_ready_timeout", nif.req_ready, 1'b1);
    nif.req_valid = 1'b1;
    nif.x_Dest = x;
    nif.y_Dest = y;
    nif.pkt_len = len;
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    nif.req_valid = 1'b0;
    nif.x_Dest = 5'($urandom);
    nif.y_Dest = 5'($urandom);
    nif.pkt_len = 4'($urandom);
  endtask

  task automatic feed_cyc();
    bit hs;
    @(negedge clk);
    nif.data_valid = ($urandom_range(99) < vprob);
    nif.data_in = (widx < wq.size()) ? wq[widx] : 30'($urandom);
    #1;
    if (nif.req_ready === 1'b1) rr_viol++;
    hs = nif.data_valid && (nif.data_ready === 1'b1);
    @(posedge clk);
    if (hs) widx++;
  endtask

  task automatic feed_until(input int target, input int budget);
    int b = 0;
    while (widx < target && b < budget) begin feed_cyc(); b++; end
    if (widx < target) chk("feed_timeout", widx, target);
    #1;
    nif.data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    @(negedge clk);
    while (nif.req_ready !== 1'b1 && b < 50) begin @(negedge clk); b++; end
    if (b >= 50) chk("idle_timeout", nif.req_ready, 1'b1);
  endtask

  task automatic do_pkt(input logic [4:0] x, input logic [4:0] y, input logic [3:0] len,
                        input bit fixed);
    start_pkt(x, y, len, fixed);
    feed_until(int'(len), 400);
    if (len > 0) begin
      chk("rdy_after_tail", nif.req_ready, 1'b1);
      chk("rdy_low_in_pkt", rr_viol, 0);
    end else wait_idle();
  endtask

  task automatic cmp_flits(input string tag);
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s_flit%0d", tag, i), got[i], expq[i]);
    got.delete();
    got_cyc.delete();
    expq.delete();
  endtask

  task automatic stall_check(input string tag, input int exp_cnt);
    repeat (10) feed_cyc();
    @(negedge clk);
    chk({tag, "_cnt"}, got.size(), exp_cnt);
    chk({tag, "_dready"}, nif.data_ready, 1'b0);
  endtask

  task automatic finish_pkt(input int ncred, input string tag);
    repeat (ncred) due.push_back(cyc);
    rtr_en = 1'b1;
    rtr_dly = 2;
    feed_until(wq.size(), 100);
    repeat (12) @(negedge clk);
    cmp_flits(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    nif.req_valid = 1'b0;
    nif.x_Dest = '0;
    nif.y_Dest = '0;
    nif.pkt_len = '0;
    nif.data_valid = 1'b0;
    nif.data_in = '0;
    #2;
    chk("rst_req_ready", nif.req_ready, 1'b1);
    chk("rst_data_ready", nif.data_ready, 1'b0);
    chk("rst_flit_valid", nif.flit_valid, 1'b0);
    chk("rst_flit_out", nif.flit_out, 32'h0);
    chk("rst_credit_err", nif.credit_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // T1: single HEADTAIL flit, latency N+2, no credit returned
    rtr_en = 1'b0;
    start_pkt(5'd5, 5'd5, 4'd0, 1'b0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t1_count", got.size(), 1);
    if (got.size() >= 1) begin
      chk("t1_flit", got[0], 32'hC00000A5);
      chk("t1_latency", got_cyc[0], acc_cyc + 2);
    end
    cmp_flits("t1");

    // T3: three credits left -> three flits, then one credit -> one more
    start_pkt(5'd3, 5'd7, 4'd5, 1'b0);
    stall_check("t3_a", 3);
    due.push_back(cyc);
    stall_check("t3_b", 4);
    finish_pkt(4, "t3");

    // T2: back-to-back 4-flit packet
    rtr_en = 1'b1;
    rtr_dly = 2;
    vprob = 100;
    do_pkt(5'd1, 5'd2, 4'd3, 1'b1);
    repeat (10) @(negedge clk);
    chk("t2_count", got_cyc.size(), 4);
    if (got_cyc.size() == 4) begin
      chk("t2_first", got_cyc[0], acc_cyc + 2);
      chk("t2_last", got_cyc[3], acc_cyc + 5);
    end
    cmp_flits("t2");

    // T4: 16-flit packet with credits returning in issue cycles
    do_pkt(5'($urandom), 5'($urandom), 4'd15, 1'b0);
    repeat (12) @(negedge clk);
    chk("t4_count", got_cyc.size(), 16);
    if (got_cyc.size() == 16) chk("t4_span", got_cyc[15] - got_cyc[0], 15);
    cmp_flits("t4");
    chk("t4_no_err", nif.credit_err, 1'b0);

    // Random packets with random data gaps and router latency
    for (int p = 0; p < 12; p++) begin
      rtr_dly = $urandom_range(0, 5);
      vprob = $urandom_range(30, 100);
      do_pkt(5'($urandom), 5'($urandom), 4'($urandom), 1'b0);
      repeat (12) @(negedge clk);
      cmp_flits($sformatf("rnd%0d", p));
    end
    chk("no_overrun", (max_out <= BD), 1'b1);
    chk("rnd_no_err", nif.credit_err, 1'b0);

    // T5: reset mid-packet
    vprob = 100;
    rtr_dly = 2;
    repeat (10) @(negedge clk);
    start_pkt(5'd9, 5'd4, 4'd6, 1'b0);
    feed_until(3, 100);
    chk("t5_fv_before", nif.flit_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_fv_rst", nif.flit_valid, 1'b0);
    chk("t5_fo_rst", nif.flit_out, 32'h0);
    chk("t5_rr_rst", nif.req_ready, 1'b1);
    chk("t5_dr_rst", nif.data_ready, 1'b0);
    while (expq.size() > 3) void'(expq.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin @(negedge clk); nif.data_valid = 1'b1; end
    #1;
    chk("t5_idle_dr", nif.data_ready, 1'b0);
    chk("t5_idle_rr", nif.req_ready, 1'b1);
    nif.data_valid = 1'b0;
    repeat (6) @(negedge clk);
    cmp_flits("t5");
    rtr_en = 1'b0;
    start_pkt(5'd2, 5'd2, 4'd5, 1'b0);
    stall_check("t5_cred", 4);
    finish_pkt(4, "t5b");

    // T6: extra credit at full count
    repeat (10) @(negedge clk);
    chk("t6_pre_err", nif.credit_err, 1'b0);
    due.push_back(cyc);
    repeat (3) @(negedge clk);
    chk("t6_err", nif.credit_err, EXP_ERR);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", nif.credit_err, EXP_ERR);
    rtr_en = 1'b0;
    start_pkt(5'd6, 5'd1, 4'd5, 1'b0);
    stall_check("t6_sat", 4);
    finish_pkt(4, "t6");
    chk("t6_err_end", nif.credit_err, EXP_ERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
